ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width (2**ADDR_WIDTH words).
REQ-003 Parameter MAX_BURST, default 4, range 1..15, SHALL set the maximum consecutive grants to one client while the other client is requesting.
REQ-004 Port clk, input, 1 bit: single clock; all logic SHALL be rising-edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 Ports req0/req1, input, 1 bit each: client access request, held until granted.
REQ-007 Ports we0/we1, input, 1 bit each: 1 = write, 0 = read; sampled with req.
REQ-008 Ports addr0/addr1, input, ADDR_WIDTH each: access address.
REQ-009 Ports wdata0/wdata1, input, DATA_WIDTH each: write data.
REQ-010 Ports gnt0/gnt1, output, 1 bit each: combinational grant; access completes in the cycle gnt is high.
REQ-011 Ports rvalid0/rvalid1, output, 1 bit each: registered read-data-valid strobe.
REQ-012 Port rdata, output, DATA_WIDTH: read data shared by both clients, qualified by rvalid0/rvalid1.

Function
REQ-013 The block SHALL own one dual-port RAM and perform at most one access, read or write, per cycle.
REQ-014 The grant SHALL be one-hot or zero: gnt0 & gnt1 never both 1.
REQ-015 A gnt output SHALL be high only when the matching req is high.
REQ-016 FSM states IDLE, OWN0 and OWN1 SHALL select the client to be granted.
REQ-017 In IDLE, a single requester SHALL be granted.
REQ-018 In IDLE with both requesting, the client not granted most recently SHALL win; after reset client 0 wins.
REQ-019 In OWNn, a held reqn SHALL keep the grant with client n while the other client is idle, with no burst limit.
REQ-020 In OWNn with both requesting, the grant SHALL pass to the other client after MAX_BURST consecutive grants to n.
REQ-021 Burst counter: 4-bit; reset to 1 on ownership change; incremented per consecutive grant to the same client; saturates at MAX_BURST.
REQ-022 In OWNn, if reqn drops, the grant SHALL move to the other client in the same cycle if it is requesting, else the FSM SHALL return to IDLE.
REQ-023 A granted write SHALL write wdataN to addrN at that clock edge.
REQ-024 A granted read SHALL drive the RAM read address with addrN; rdata SHALL carry the word one cycle later with rvalidN = 1 for exactly that cycle.
REQ-025 rdata SHALL reflect writes completed in any earlier cycle; no same-cycle read/write hazard exists (REQ-013).
REQ-026 With no grant, the RAM write enable SHALL be 0 and rvalid0/rvalid1 SHALL be 0 on the next cycle.
REQ-027 Back-to-back reads, alternating or same-client, SHALL sustain one rvalid per cycle.

Reset
REQ-028 While rst is high at a clock edge, the FSM SHALL go to IDLE, the burst counter to 0, last-granted to client 1, and rvalid0/rvalid1 to 0.
REQ-029 While rst is high, gnt0/gnt1 SHALL be 0 and no RAM write SHALL occur.
REQ-030 An in-flight read interrupted by reset SHALL NOT produce rvalid.
REQ-031 RAM contents SHALL NOT be cleared by reset; they are loaded only by the RAM's own initialisation.

Structure
REQ-032 FSM state encodings and default parameter values SHALL live in a shared constants header included by the arbiter and its bench.
REQ-033 The RAM SHALL be the existing dual_port_ram sub-module instantiated once; no other sub-module.
REQ-034 The RAM write address and the RAM read address SHALL both be driven from the granted client's addrN.

Verification
REQ-035 Reset, then req0=1, we0=1, addr0=3, wdata0=8'hA5 for 1 cycle -> gnt0=1; a later client-1 read of addr 3 -> rvalid1=1 next cycle, rdata=8'hA5.
REQ-036 Both requesting continuous reads, MAX_BURST=4, starting from reset -> grant pattern 0,0,0,0,1,1,1,1,0...; gnt0 & gnt1 never both 1.
REQ-037 req0 held 10 cycles with req1=0 -> gnt0 high all 10 cycles; req1 rises in cycle 10 -> gnt1 no later than 4 cycles after.
REQ-038 Both read simultaneously from IDLE after client 0 was last granted -> client 1 wins first.
REQ-039 rst asserted in the cycle after a granted read -> no rvalid; after reset, gnt0=gnt1=0 and the FSM is in IDLE.
REQ-040 Random req/we/addr for 10k cycles against a reference memory model -> every rvalid rdata matches the model; no starvation beyond MAX_BURST cycles.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_pkg
//  Description : Shared constants, FSM state encoding and client identifiers
//                for the two-client RAM arbiter and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    // Default parameter values shared by the arbiter, its interface and bench
    localparam int c_def_data_width = 8;
    localparam int c_def_addr_width = 4;
    localparam int c_def_max_burst  = 4;

    // Width of the consecutive-grant counter (covers MAX_BURST up to 15)
    localparam int c_cnt_width = 4;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Client identifier used for the last-granted record
    typedef enum logic {
        CL0 = 1'b0,
        CL1 = 1'b1
    } client_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_if
//  Description : Two-client request/grant bus with shared read data.
//                master = client side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int ADDR_WIDTH = c_def_addr_width
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );

endinterface
`default_nettype wire

// File: rtl/dual_port_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_ram
//  Description : Simple dual-port RAM, one write port and one registered
//                read port. Contents are never cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [ADDR_WIDTH-1:0] waddr,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    input  wire logic                  re,
    input  wire logic [ADDR_WIDTH-1:0] raddr,
    output      logic [DATA_WIDTH-1:0] rdata
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [c_depth];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Read data register only loads on an enabled read, otherwise holds
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage write and read-data register; no reset on purpose
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Arbitrates two clients onto one dual-port RAM, one access
//                per cycle. Combinational grant, burst-limited ownership
//                while both clients compete, registered read-valid strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int ADDR_WIDTH = c_def_addr_width,
    parameter int MAX_BURST  = c_def_max_burst
) (
    input wire logic    clk,
    input wire logic    rst,
    ram_arbiter_if.slave bus
);

    localparam logic [c_cnt_width-1:0] c_max_burst = c_cnt_width'(MAX_BURST);
    localparam logic [c_cnt_width-1:0] c_cnt_one   = c_cnt_width'(1);

    state_t                 state_q, state_d;
    logic [c_cnt_width-1:0] cnt_q, cnt_d;
    client_t                last_q, last_d;
    logic                   rvalid0_q, rvalid0_d;
    logic                   rvalid1_q, rvalid1_d;

    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_burst_done;
    logic                   w_ram_we;
    logic                   w_ram_re;
    logic [ADDR_WIDTH-1:0]  w_ram_addr;
    logic [DATA_WIDTH-1:0]  w_ram_wdata;
    logic [DATA_WIDTH-1:0]  w_ram_rdata;

    // Current owner has used up its burst allowance
    assign w_burst_done = (cnt_q >= c_max_burst);

    // Grant selection, next ownership state and burst counting
    always_comb begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        state_d = ST_IDLE;
        cnt_d   = '0;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    // Contention from idle: the client not served last wins
                    if (last_q == CL1) w_gnt0 = 1'b1;
                    else               w_gnt1 = 1'b1;
                end else if (bus.req0) begin
                    w_gnt0 = 1'b1;
                end else if (bus.req1) begin
                    w_gnt1 = 1'b1;
                end
            end
            ST_OWN0: begin
                if (bus.req0) begin
                    if (bus.req1 && w_burst_done) w_gnt1 = 1'b1;
                    else                          w_gnt0 = 1'b1;
                end else if (bus.req1) begin
                    w_gnt1 = 1'b1;
                end
            end
            ST_OWN1: begin
                if (bus.req1) begin
                    if (bus.req0 && w_burst_done) w_gnt0 = 1'b1;
                    else                          w_gnt1 = 1'b1;
                end else if (bus.req0) begin
                    w_gnt0 = 1'b1;
                end
            end
            default: begin
                // Unused encoding: grant nothing and fall back to idle
            end
        endcase

        // No access of any kind while reset is held
        if (rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end

        if (w_gnt0) begin
            state_d = ST_OWN0;
            last_d  = CL0;
            if (state_q == ST_OWN0) cnt_d = w_burst_done ? cnt_q : cnt_q + c_cnt_one;
            else                    cnt_d = c_cnt_one;
        end else if (w_gnt1) begin
            state_d = ST_OWN1;
            last_d  = CL1;
            if (state_q == ST_OWN1) cnt_d = w_burst_done ? cnt_q : cnt_q + c_cnt_one;
            else                    cnt_d = c_cnt_one;
        end
    end

    // RAM port steering from the granted client
    always_comb begin
        w_ram_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
        w_ram_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;
        w_ram_we    = (w_gnt0 & bus.we0)  | (w_gnt1 & bus.we1);
        w_ram_re    = (w_gnt0 & ~bus.we0) | (w_gnt1 & ~bus.we1);
        rvalid0_d   = w_gnt0 & ~bus.we0;
        rvalid1_d   = w_gnt1 & ~bus.we1;
    end

    // State, counter, last-granted and read-valid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= CL1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (w_ram_addr),
        .wdata (w_ram_wdata),
        .re    (w_ram_re),
        .raddr (w_ram_addr),
        .rdata (w_ram_rdata)
    );

    // A read in flight when reset arrives must not surface as valid data
    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = rvalid0_q & ~rst;
    assign bus.rvalid1 = rvalid1_q & ~rst;
    assign bus.rdata   = w_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter: directed scenarios plus
//                random traffic against a history-based grant model and a
//                reference memory; read data checked through a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int DATA_WIDTH = c_def_data_width;
    localparam int ADDR_WIDTH = c_def_addr_width;
    localparam int MAX_BURST  = c_def_max_burst;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int N_RANDOM   = 10000;

    typedef struct {
        int                    client;
        int                    due;
        bit                    known;
        logic [DATA_WIDTH-1:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    ram_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: grant history and memory image
    int                    prev_gnt  = -1;
    int                    streak    = 0;
    int                    last_gnt  = 1;
    int                    exp_last  = -1;
    int                    wait0     = 0;
    int                    wait1     = 0;
    logic [DATA_WIDTH-1:0] mem_m   [DEPTH];
    bit                    known_m [DEPTH];
    rd_t                   sb_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Grant model: decides the expected grant from request pattern and history
    always @(negedge clk) begin
        int                    e;
        int                    a;
        logic                  w;
        logic [DATA_WIDTH-1:0] d;
        rd_t                   r;
        if (rst) begin
            e        = -1;
            prev_gnt = -1;
            streak   = 0;
            last_gnt = 1;
            wait0    = 0;
            wait1    = 0;
        end else if (bus.req0 && bus.req1) begin
            if (prev_gnt >= 0 && streak < MAX_BURST) e = prev_gnt;
            else if (prev_gnt >= 0)                  e = 1 - prev_gnt;
            else                                     e = 1 - last_gnt;
        end else if (bus.req0) begin
            e = 0;
        end else if (bus.req1) begin
            e = 1;
        end else begin
            e = -1;
        end

        check("gnt0", 32'(bus.gnt0), 32'(e == 0));
        check("gnt1", 32'(bus.gnt1), 32'(e == 1));

        if (!rst) begin
            if (bus.req0 && !bus.gnt0) wait0++; else wait0 = 0;
            if (bus.req1 && !bus.gnt1) wait1++; else wait1 = 0;
            if (wait0 > 0) check("starve0", 32'(wait0 <= MAX_BURST), 32'd1);
            if (wait1 > 0) check("starve1", 32'(wait1 <= MAX_BURST), 32'd1);

            if (e >= 0 && e == prev_gnt) streak++;
            else                         streak = (e >= 0) ? 1 : 0;
            prev_gnt = e;
            if (e >= 0) last_gnt = e;

            if (e >= 0) begin
                a = (e == 0) ? int'(bus.addr0) : int'(bus.addr1);
                w = (e == 0) ? bus.we0 : bus.we1;
                d = (e == 0) ? bus.wdata0 : bus.wdata1;
                if (w) begin
                    mem_m[a]   = d;
                    known_m[a] = 1'b1;
                end else begin
                    r.client = e;
                    r.due    = cyc + 1;
                    r.known  = known_m[a];
                    r.data   = mem_m[a];
                    sb_q.push_back(r);
                end
            end
        end
        exp_last = e;
    end

    // Read-data monitor: pops the scoreboard whenever a read-valid appears
    always @(negedge clk) begin
        rd_t r;
        if (rst) begin
            check("rvalid0_in_reset", 32'(bus.rvalid0), 32'd0);
            check("rvalid1_in_reset", 32'(bus.rvalid1), 32'd0);
            sb_q.delete();
        end else if (bus.rvalid0 || bus.rvalid1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rvalid_spurious @cycle %0d: actual rvalid0=%0b rvalid1=%0b required none",
                         cyc, bus.rvalid0, bus.rvalid1);
            end else begin
                r = sb_q.pop_front();
                check("rvalid_cycle", 32'(cyc), 32'(r.due));
                check("rvalid0", 32'(bus.rvalid0), 32'(r.client == 0));
                check("rvalid1", 32'(bus.rvalid1), 32'(r.client == 1));
                if (r.known) check("rdata", 32'(bus.rdata), 32'(r.data));
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            r = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL rvalid_missing @cycle %0d: actual none required rvalid%0d", cyc, r.client);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic read0(input logic [ADDR_WIDTH-1:0] a);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = a;
    endtask

    task automatic read1(input logic [ADDR_WIDTH-1:0] a);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = a;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Write A5 to address 3 from client 0, read it back from client 1
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 8'hA5;
        @(negedge clk); check("wr_gnt0", 32'(bus.gnt0), 32'd1);
        step(); idle_inputs();
        step(); read1(4'd3);
        @(negedge clk); check("rd_gnt1", 32'(bus.gnt1), 32'd1);
        step(); idle_inputs();
        @(negedge clk);
        check("rd_rvalid1", 32'(bus.rvalid1), 32'd1);
        check("rd_rdata_a5", 32'(bus.rdata), 32'hA5);
        step();

        // Client 0 served last, idle, then both: client 1 must win
        read0(4'd3);
        @(negedge clk); check("last0_gnt0", 32'(bus.gnt0), 32'd1);
        step(); idle_inputs();
        step(); read0(4'd3); read1(4'd3);
        @(negedge clk); check("fair_gnt1", 32'(bus.gnt1), 32'd1);
        step(); idle_inputs();
        step();

        // Reset right after a granted read: no read-valid, arbiter back in idle
        read0(4'd3);
        @(negedge clk); check("pre_rst_gnt0", 32'(bus.gnt0), 32'd1);
        step(); rst = 1'b1; idle_inputs();
        @(negedge clk);
        check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        check("rst_gnt0", 32'(bus.gnt0), 32'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        check("post_rst_gnt_none", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        step(); read0(4'd3); read1(4'd3);
        @(negedge clk); check("post_rst_idle_gnt0", 32'(bus.gnt0), 32'd1);
        step(); idle_inputs();
        step();

        // Continuous contention from reset: bursts of MAX_BURST alternate
        pulse_reset();
        read0(4'd3); read1(4'd3);
        for (int i = 0; i < 3 * MAX_BURST; i++) begin
            @(negedge clk);
            check("burst_pattern", 32'(bus.gnt1), 32'((i / MAX_BURST) % 2));
            check("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            step();
        end
        idle_inputs();
        step();

        // Long solo ownership, then the other client must get in quickly
        pulse_reset();
        read0(4'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("solo_gnt0", 32'(bus.gnt0), 32'd1);
            step();
        end
        read1(4'd3);
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.gnt1 && lat < 0) lat = k;
            step();
        end
        check("gnt1_latency_ok", 32'(lat >= 0 && lat <= 4), 32'd1);
        idle_inputs();
        step();

        // Random traffic; a request is held until the model says it was granted
        for (int i = 0; i < N_RANDOM; i++) begin
            if (!bus.req0 || exp_last == 0) begin
                bus.req0   = ($urandom_range(99) < 60);
                bus.we0    = ($urandom_range(99) < 35);
                bus.addr0  = ADDR_WIDTH'($urandom);
                bus.wdata0 = DATA_WIDTH'($urandom);
            end
            if (!bus.req1 || exp_last == 1) begin
                bus.req1   = ($urandom_range(99) < 60);
                bus.we1    = ($urandom_range(99) < 35);
                bus.addr1  = ADDR_WIDTH'($urandom);
                bus.wdata1 = DATA_WIDTH'($urandom);
            end
            step();
        end

        idle_inputs();
        repeat (4) step();
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
